pio_in_edge_irq: RTL and testbench

//  Parametrised Avalon-MM input PIO, successor to the fixed 4-bit switch PIO.

---
 rtl/pio_pkg.sv | 34 +++
 rtl/pio_debounce_bit.sv | 45 ++++
 rtl/pio_in_edge_irq.sv | 135 +++++++++++++
 tb/tb_pio_in_edge_irq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared register map, edge/irq type encodings and the per-bit edge selector
// for the Avalon-MM input PIO.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_RSVD = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    typedef enum logic {
        IRQ_LEVEL = 1'b0,
        IRQ_EDGE  = 1'b1
    } irq_type_e;

    // True when the transition prv -> cur matches the configured edge type.
    function automatic logic edge_hit(input edge_type_e et, input logic cur, input logic prv);
        logic rise;
        logic fall;
        rise = cur & ~prv;
        fall = ~cur & prv;
        case (et)
            EDGE_RISE: edge_hit = rise;
            EDGE_FALL: edge_hit = fall;
            default:   edge_hit = rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One-bit debounce filter: q follows d only after d has differed from q for
// CYCLES consecutive clocks; any bounce restarts the count.
module pio_debounce_bit #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          q_reg;
    logic          q_next;

    always_comb begin
        cnt_next = cnt_reg;
        q_next   = q_reg;
        if (d == q_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == LAST) begin
            cnt_next = '0;
            q_next   = d;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
            q_reg   <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            q_reg   <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pio_in_edge_irq.sv
// Parametrised Avalon-MM input PIO with per-bit edge capture and maskable IRQ.
// Optional debounce filter on every input bit when PIO_IN_DEBOUNCE_EN is defined.
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_TYPE        = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] EDGE_CODE   = 2'(EDGE_TYPE);
    localparam edge_type_e EDGE_SEL    = edge_type_e'(EDGE_CODE);
    localparam bit         IRQ_IS_EDGE = (IRQ_TYPE == int'(IRQ_EDGE));

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] cap_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [31:0]      readdata_reg;
    logic [31:0]      readdata_next;
    logic             irq_reg;
    logic             irq_next;
    logic             wr_en;
    logic             unused_wdata;

    // Bits of writedata above WIDTH are deliberately dropped.
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
            pio_debounce_bit #(
                .CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk  (clk),
                .reset(reset),
                .d    (sync2_reg[gi]),
                .q    (filt[gi])
            );
        end
    endgenerate
`else
    localparam int unused_db_cycles = DEBOUNCE_CYCLES;
    assign filt = sync2_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= filt;
        end
    end

    assign wr_en = chipselect & ~write_n;
    assign clr   = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // A new edge takes priority over a clear in the same cycle, so no edge is lost.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_capture
            assign sel[gi] = edge_hit(EDGE_SEL, filt[gi], prev_reg[gi]);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cap_reg[gi] <= 1'b0;
                end else if (sel[gi]) begin
                    cap_reg[gi] <= 1'b1;
                end else if (clr[gi]) begin
                    cap_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_reg <= '0;
        end else if (wr_en && address == ADDR_MASK) begin
            mask_reg <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA: readdata_next = 32'(filt);
            ADDR_MASK: readdata_next = 32'(mask_reg);
            ADDR_EDGE: readdata_next = 32'(cap_reg);
            default:   readdata_next = '0;
        endcase
    end

    always_comb begin
        irq_next = IRQ_IS_EDGE ? |(cap_reg & mask_reg) : |(filt & mask_reg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            readdata_reg <= readdata_next;
            irq_reg      <= irq_next;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = irq_reg;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Scoreboard bench for pio_in_edge_irq: three instances (rise/edge-irq,
// any-edge/edge-irq, rise/level-irq) share one bus and one input bank.
module tb_pio_in_edge_irq;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic [2:0]  cs;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rdata [3];
    logic [2:0]  irqs;
    logic        rd_req;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          inst;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          chk_irq;
        bit          exp_irq;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(1), .DEBOUNCE_CYCLES(16)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[0]), .in_port(in_port), .irq(irqs[0])
    );
    pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_TYPE(1), .DEBOUNCE_CYCLES(16)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[1]), .in_port(in_port), .irq(irqs[1])
    );
    pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(0), .DEBOUNCE_CYCLES(16)) u_lvl (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[2]), .in_port(in_port), .irq(irqs[2])
    );

    // One bus cycle, entered and left at a falling edge; optionally queues an expectation.
    task automatic cycle(input logic [2:0] cs_v, input bit wr, input logic [1:0] a,
                         input logic [31:0] d, input int inst, input bit chk_rd,
                         input logic [31:0] e_rd, input bit chk_irq, input bit e_irq,
                         input string nm);
        exp_t e;
        cs        = cs_v;
        write_n   = ~wr;
        address   = a;
        writedata = d;
        if (chk_rd || chk_irq) begin
            e.inst = inst; e.chk_rd = chk_rd; e.exp_rd = e_rd;
            e.chk_irq = chk_irq; e.exp_irq = e_irq; e.name = nm;
            sb_q.push_back(e);
            rd_req = 1'b1;
        end else begin
            rd_req = 1'b0;
        end
        @(negedge clk);
        cs      = '0;
        write_n = 1'b1;
        rd_req  = 1'b0;
    endtask

    task automatic rd(input int inst, input logic [1:0] a, input logic [31:0] e,
                      input bit e_irq, input string nm);
        cycle(3'b000, 1'b0, a, 32'h0, inst, 1'b1, e, 1'b1, e_irq, nm);
    endtask

    task automatic wr(input logic [2:0] c, input logic [1:0] a, input logic [31:0] d);
        cycle(c, 1'b1, a, d, 0, 1'b0, 32'h0, 1'b0, 1'b0, "");
    endtask

    task automatic wr_irq(input logic [2:0] c, input logic [1:0] a, input logic [31:0] d,
                          input int inst, input bit e_irq, input string nm);
        cycle(c, 1'b1, a, d, inst, 1'b0, 32'h0, 1'b1, e_irq, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: a queued transaction's response is valid just after the next rising edge.
    initial begin : monitor
        logic take;
        exp_t e;
        forever begin
            @(posedge clk);
            take = rd_req;
            #1;
            if (take) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: response with no queued expectation");
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk_rd) begin
                        checks++;
                        if (rdata[e.inst] !== e.exp_rd) begin
                            failures++;
                            $display("FAIL %s inst=%0d readdata=%h required=%h",
                                     e.name, e.inst, rdata[e.inst], e.exp_rd);
                        end
                    end
                    if (e.chk_irq) begin
                        checks++;
                        if (irqs[e.inst] !== e.exp_irq) begin
                            failures++;
                            $display("FAIL %s inst=%0d irq=%b required=%b",
                                     e.name, e.inst, irqs[e.inst], e.exp_irq);
                        end
                    end
                    $display("txn %s inst=%0d readdata=%h irq=%b", e.name, e.inst,
                             rdata[e.inst], irqs[e.inst]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1'b0; cs = '0; write_n = 1'b1; address = '0;
        writedata = '0; in_port = '0; rd_req = 1'b0;
        #3 reset = 1'b1;
        idle(2);
        rd(0, 2'd0, 32'h0, 1'b0, "rst_hold");
        reset = 1'b0;
        rd(0, 2'd1, 32'h0, 1'b0, "rst_mask");
        rd(0, 2'd3, 32'h0, 1'b0, "rst_cap");
        rd(1, 2'd3, 32'h0, 1'b0, "rst_cap_any");
        rd(2, 2'd0, 32'h0, 1'b0, "rst_data_lvl");
`ifndef PIO_IN_DEBOUNCE_EN
        // Two-flop synchroniser: value visible on the third read.
        in_port = 8'hA5;
        rd(0, 2'd0, 32'h0,  1'b0, "lat_p1");
        rd(0, 2'd0, 32'h0,  1'b0, "lat_p2");
        rd(0, 2'd0, 32'hA5, 1'b0, "lat_p3");
        in_port = 8'h00;
        idle(4);
        wr(3'b111, 2'd3, 32'hFF);
        rd(0, 2'd3, 32'h0, 1'b0, "clr_all_rise");
        rd(1, 2'd3, 32'h0, 1'b0, "clr_all_any");

        // Rising edge on bit0, edge irq with mask 0x01.
        wr(3'b001, 2'd1, 32'h01);
        rd(0, 2'd1, 32'h01, 1'b0, "mask_rb");
        in_port = 8'h01;
        rd(0, 2'd3, 32'h0,  1'b0, "t2_c1");
        rd(0, 2'd3, 32'h0,  1'b0, "t2_c2");
        rd(0, 2'd3, 32'h0,  1'b0, "t2_c3");
        rd(0, 2'd3, 32'h01, 1'b1, "t2_cap_irq");
        wr_irq(3'b001, 2'd3, 32'h01, 0, 1'b1, "w1c_cycle");
        rd(0, 2'd3, 32'h0, 1'b0, "w1c_irq_drop");

        // Clear bits above WIDTH only: no effect.
        wr(3'b010, 2'd3, 32'hFFFF_FF00);
        rd(1, 2'd3, 32'h01, 1'b0, "w1c_hi_bits");
        wr(3'b010, 2'd3, 32'h01);
        rd(1, 2'd3, 32'h0, 1'b0, "any_clr");

        // Writes to data and reserved addresses are ignored.
        wr(3'b001, 2'd0, 32'hFF);
        wr(3'b001, 2'd2, 32'hFF);
        rd(0, 2'd1, 32'h01, 1'b0, "mask_after_ign");
        rd(0, 2'd2, 32'h0,  1'b0, "addr2_zero");

        // Edge on bit2 arrives in the same cycle as its clear.
        in_port = 8'h05;
        idle(2);
        wr(3'b001, 2'd3, 32'h04);
        rd(0, 2'd3, 32'h04, 1'b0, "same_cycle");
        wr(3'b001, 2'd3, 32'h04);
        rd(0, 2'd3, 32'h0, 1'b0, "t3_clr");
        idle(3);
        wr(3'b111, 2'd3, 32'hFF);

        // Any-edge capture with mask 0, then unmask.
        in_port = 8'h85;
        idle(4);
        in_port = 8'h05;
        idle(4);
        rd(1, 2'd3, 32'h80, 1'b0, "any_toggle");
        wr(3'b010, 2'd1, 32'h80);
        rd(1, 2'd1, 32'h80, 1'b1, "any_mask_irq");

        // Level irq follows data & mask.
        in_port = 8'h03;
        idle(4);
        wr(3'b100, 2'd3, 32'hFF);
        wr(3'b100, 2'd1, 32'h0F);
        rd(2, 2'd3, 32'h0, 1'b1, "lvl_nocap");
        in_port = 8'h00;
        rd(2, 2'd0, 32'h03, 1'b1, "lvl_p1");
        rd(2, 2'd0, 32'h03, 1'b1, "lvl_p2");
        rd(2, 2'd0, 32'h00, 1'b0, "lvl_p3");
`else
        // 10-clk glitch on bit1 never reaches the filtered value.
        in_port = 8'h02;
        idle(10);
        in_port = 8'h00;
        idle(4);
        rd(0, 2'd0, 32'h0, 1'b0, "glitch_data");
        rd(0, 2'd3, 32'h0, 1'b0, "glitch_cap");
        // Stable high: filtered value flips 2+16 clk after the input change.
        in_port = 8'h02;
        idle(17);
        rd(0, 2'd0, 32'h0,  1'b0, "db_p18");
        rd(0, 2'd0, 32'h02, 1'b0, "db_p19");
        rd(0, 2'd3, 32'h02, 1'b0, "db_cap");
`endif
        idle(2);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain: pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
